pipe_link_monitor: RTL and testbench

Single-lane PIPE symbol-stream monitor and pipeline stage, inserted on one direction of the 8-bit + K link between two `pcieVHostPipex1` nodes (e.g. RC TxData → EP RxData). It delays the stream by one register stage and parses it in-line. It flags SKP ordered sets, TS1/TS2 ordered sets, TLP and DLLP framing, and framing errors. It also keeps wrap-around event counters for the test harness.

---
 rtl/pipe_link_monitor.sv | 244 ++++++++++++++++++++++++
 tb/tb_pipe_link_monitor.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_link_monitor.sv
// pipe_link_monitor: one-stage pipeline register on an 8b+K PIPE symbol lane
// with an in-line parser for SKP/TS1/TS2 ordered sets, TLP and DLLP framing.
// Every output is registered. Event pulses and counter updates appear on
// the same cycle as the terminating symbol appears on TxData.
module pipe_link_monitor #(
  parameter int CNT_WIDTH    = 16,
  parameter int MIN_TLP_SYMS = 20,
  parameter int MAX_TLP_SYMS = 4124
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic [7:0]           RxData,
  input  logic                 RxDataK,
  input  logic                 ClrCounts,
  output logic [7:0]           TxData,
  output logic                 TxDataK,
  output logic                 SkpSeen,
  output logic                 Ts1Seen,
  output logic                 Ts2Seen,
  output logic                 TlpEnd,
  output logic                 TlpNull,
  output logic                 DllpEnd,
  output logic                 FrameErr,
  output logic [12:0]          TlpLen,
  output logic [CNT_WIDTH-1:0] TlpCount,
  output logic [CNT_WIDTH-1:0] DllpCount,
  output logic [CNT_WIDTH-1:0] SkpCount,
  output logic [CNT_WIDTH-1:0] ErrCount
);

  // Control (K) and identifier (D) codes
  localparam logic [7:0] K_COM  = 8'hBC;
  localparam logic [7:0] K_SKP  = 8'h1C;
  localparam logic [7:0] K_PAD  = 8'hF7;
  localparam logic [7:0] K_STP  = 8'hFB;
  localparam logic [7:0] K_SDP  = 8'h5C;
  localparam logic [7:0] K_END  = 8'hFD;
  localparam logic [7:0] K_EDB  = 8'hFE;
  localparam logic [7:0] ID_TS1 = 8'h4A;
  localparam logic [7:0] ID_TS2 = 8'h45;

  localparam logic [12:0]          MIN_LEN = 13'(MIN_TLP_SYMS);
  localparam logic [12:0]          MAX_LEN = 13'(MAX_TLP_SYMS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OS_HDR,
    S_SKP,
    S_TS,
    S_TLP,
    S_DLLP
  } state_t;

  state_t      state_reg;
  logic [3:0]  idx_reg;   // index of the symbol expected next within the frame
  logic [12:0] len_reg;   // TLP symbols seen so far, STP included
  logic [7:0]  id_reg;    // TS identifier captured at idx 6

  state_t      idle_state;
  logic        idle_err;
  logic [12:0] len_inc;

  // How the current symbol would be handled in IDLE. Used both in IDLE and
  // when an aborted frame hands its offending symbol back for re-evaluation.
  always_comb begin
    idle_state = S_IDLE;
    idle_err   = 1'b0;
    if (RxDataK) begin
      case (RxData)
        K_COM:   idle_state = S_OS_HDR;
        K_STP:   idle_state = S_TLP;
        K_SDP:   idle_state = S_DLLP;
        default: idle_err   = 1'b1;
      endcase
    end else if (RxData != 8'h00) begin
      idle_err = 1'b1;
    end
  end

  // TLP length including the current symbol, saturating at the 13-bit maximum
  assign len_inc = (len_reg == 13'h1FFF) ? len_reg : len_reg + 13'd1;

  // Parser FSM, pipeline register, event pulses and counters
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      len_reg   <= '0;
      id_reg    <= '0;
      TxData    <= '0;
      TxDataK   <= 1'b0;
      SkpSeen   <= 1'b0;
      Ts1Seen   <= 1'b0;
      Ts2Seen   <= 1'b0;
      TlpEnd    <= 1'b0;
      TlpNull   <= 1'b0;
      DllpEnd   <= 1'b0;
      FrameErr  <= 1'b0;
      TlpLen    <= '0;
      TlpCount  <= '0;
      DllpCount <= '0;
      SkpCount  <= '0;
      ErrCount  <= '0;
    end else begin
      TxData   <= RxData;
      TxDataK  <= RxDataK;
      SkpSeen  <= 1'b0;
      Ts1Seen  <= 1'b0;
      Ts2Seen  <= 1'b0;
      TlpEnd   <= 1'b0;
      TlpNull  <= 1'b0;
      DllpEnd  <= 1'b0;
      FrameErr <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          state_reg <= idle_state;
          idx_reg   <= 4'd1;
          len_reg   <= 13'd1;
          if (idle_err) begin
            FrameErr <= 1'b1;
            ErrCount <= ErrCount + CNT_ONE;
          end
        end

        S_OS_HDR: begin
          idx_reg <= 4'd2;
          if (RxDataK && RxData == K_SKP) begin
            state_reg <= S_SKP;
          end else if (!RxDataK || RxData == K_PAD) begin
            state_reg <= S_TS;
          end else begin
            // FTS, IDL and other ordered sets are passed through unchecked
            state_reg <= S_IDLE;
          end
        end

        S_SKP: begin
          if (RxDataK && RxData == K_SKP) begin
            if (idx_reg == 4'd3) begin
              SkpSeen   <= 1'b1;
              SkpCount  <= SkpCount + CNT_ONE;
              state_reg <= S_IDLE;
            end else begin
              idx_reg <= idx_reg + 4'd1;
            end
          end else begin
            // short SKP set: the intruder may itself start a new frame
            FrameErr  <= 1'b1;
            ErrCount  <= ErrCount + CNT_ONE;
            state_reg <= idle_state;
            idx_reg   <= 4'd1;
            len_reg   <= 13'd1;
          end
        end

        S_TS: begin
          if (idx_reg <= 4'd5) begin
            if (RxDataK && RxData != K_PAD) begin
              FrameErr  <= 1'b1;
              ErrCount  <= ErrCount + CNT_ONE;
              state_reg <= S_IDLE;
            end else begin
              idx_reg <= idx_reg + 4'd1;
            end
          end else if (!RxDataK && (RxData == ID_TS1 || RxData == ID_TS2) &&
                       (idx_reg == 4'd6 || RxData == id_reg)) begin
            id_reg <= RxData;
            if (idx_reg == 4'd15) begin
              if (RxData == ID_TS1) Ts1Seen <= 1'b1;
              else                  Ts2Seen <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              idx_reg <= idx_reg + 4'd1;
            end
          end else begin
            FrameErr  <= 1'b1;
            ErrCount  <= ErrCount + CNT_ONE;
            state_reg <= S_IDLE;
          end
        end

        S_TLP: begin
          if (RxDataK && RxData == K_END) begin
            TlpLen    <= len_inc;
            state_reg <= S_IDLE;
            if (len_inc >= MIN_LEN && len_inc <= MAX_LEN) begin
              TlpEnd   <= 1'b1;
              TlpCount <= TlpCount + CNT_ONE;
            end else begin
              FrameErr <= 1'b1;
              ErrCount <= ErrCount + CNT_ONE;
            end
          end else if (RxDataK && RxData == K_EDB) begin
            TlpLen    <= len_inc;
            TlpNull   <= 1'b1;
            state_reg <= S_IDLE;
          end else if (RxDataK) begin
            // unexpected K aborts the TLP; a COM here opens a new ordered set
            FrameErr  <= 1'b1;
            ErrCount  <= ErrCount + CNT_ONE;
            state_reg <= idle_state;
            idx_reg   <= 4'd1;
            len_reg   <= 13'd1;
          end else if (len_inc > MAX_LEN) begin
            FrameErr  <= 1'b1;
            ErrCount  <= ErrCount + CNT_ONE;
            state_reg <= S_IDLE;
          end else begin
            len_reg <= len_inc;
          end
        end

        S_DLLP: begin
          if (idx_reg <= 4'd6 && !RxDataK) begin
            idx_reg <= idx_reg + 4'd1;
          end else if (idx_reg == 4'd7 && RxDataK && RxData == K_END) begin
            DllpEnd   <= 1'b1;
            DllpCount <= DllpCount + CNT_ONE;
            state_reg <= S_IDLE;
          end else begin
            FrameErr  <= 1'b1;
            ErrCount  <= ErrCount + CNT_ONE;
            state_reg <= idle_state;
            idx_reg   <= 4'd1;
            len_reg   <= 13'd1;
          end
        end

        default: state_reg <= S_IDLE;
      endcase

      // A clear overrides any increment made in the same cycle
      if (ClrCounts) begin
        TlpCount  <= '0;
        DllpCount <= '0;
        SkpCount  <= '0;
        ErrCount  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_link_monitor.sv
// Testbench for pipe_link_monitor. Frames are generated with a known outcome;
// each driven symbol pushes its expected next-cycle output onto a queue and an
// independent monitor pops and compares once per cycle.
module tb_pipe_link_monitor;

  localparam int CW    = 8;
  localparam int MIN_L = 20;
  localparam int MAX_L = 4124;

  localparam logic [7:0] COM = 8'hBC, SKP = 8'h1C, PAD = 8'hF7, STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C, ENDK = 8'hFD, EDB = 8'hFE;
  localparam logic [7:0] TS1 = 8'h4A, TS2 = 8'h45;

  // event masks: {FrameErr, DllpEnd, TlpNull, TlpEnd, Ts2Seen, Ts1Seen, SkpSeen}
  localparam logic [6:0] NOEV  = 7'b0000000;
  localparam logic [6:0] E_SKP = 7'b0000001;
  localparam logic [6:0] E_TS1 = 7'b0000010;
  localparam logic [6:0] E_TS2 = 7'b0000100;
  localparam logic [6:0] E_TLP = 7'b0001000;
  localparam logic [6:0] E_NUL = 7'b0010000;
  localparam logic [6:0] E_DLL = 7'b0100000;
  localparam logic [6:0] E_ERR = 7'b1000000;

  logic          pclk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    RxData = 8'h00;
  logic          RxDataK = 1'b0;
  logic          ClrCounts = 1'b0;
  logic [7:0]    TxData;
  logic          TxDataK;
  logic          SkpSeen, Ts1Seen, Ts2Seen, TlpEnd, TlpNull, DllpEnd, FrameErr;
  logic [12:0]   TlpLen;
  logic [CW-1:0] TlpCount, DllpCount, SkpCount, ErrCount;

  pipe_link_monitor #(
    .CNT_WIDTH   (CW),
    .MIN_TLP_SYMS(MIN_L),
    .MAX_TLP_SYMS(MAX_L)
  ) dut (
    .pclk     (pclk),
    .reset    (reset),
    .RxData   (RxData),
    .RxDataK  (RxDataK),
    .ClrCounts(ClrCounts),
    .TxData   (TxData),
    .TxDataK  (TxDataK),
    .SkpSeen  (SkpSeen),
    .Ts1Seen  (Ts1Seen),
    .Ts2Seen  (Ts2Seen),
    .TlpEnd   (TlpEnd),
    .TlpNull  (TlpNull),
    .DllpEnd  (DllpEnd),
    .FrameErr (FrameErr),
    .TlpLen   (TlpLen),
    .TlpCount (TlpCount),
    .DllpCount(DllpCount),
    .SkpCount (SkpCount),
    .ErrCount (ErrCount)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [7:0]    d;
    logic          k;
    logic [6:0]    ev;
    logic [CW-1:0] tc;
    logic [CW-1:0] dc;
    logic [CW-1:0] sc;
    logic [CW-1:0] ec;
    logic [12:0]   len;
  } exp_t;

  exp_t exp_q[$];

  // reference model state: event counts and last ended TLP length
  logic [CW-1:0] m_tc = '0, m_dc = '0, m_sc = '0, m_ec = '0;
  logic [12:0]   m_len = '0;
  int checks = 0;
  int errors = 0;
  int frame_no = 0;

  // Drive one symbol and record what must appear on the outputs next cycle
  task automatic sym(input logic [7:0] d, input logic k, input logic [6:0] ev,
                     input int len_upd, input logic clr, input logic rst);
    exp_t e;
    @(negedge pclk);
    RxData    = d;
    RxDataK   = k;
    ClrCounts = clr;
    reset     = rst;
    if (rst) begin
      m_tc = '0; m_dc = '0; m_sc = '0; m_ec = '0; m_len = '0;
      e.d  = 8'h00;
      e.k  = 1'b0;
      e.ev = NOEV;
    end else begin
      if (len_upd >= 0) m_len = 13'(len_upd);
      if ((ev & E_TLP) != 0) m_tc = m_tc + 1'b1;
      if ((ev & E_DLL) != 0) m_dc = m_dc + 1'b1;
      if ((ev & E_SKP) != 0) m_sc = m_sc + 1'b1;
      if ((ev & E_ERR) != 0) m_ec = m_ec + 1'b1;
      if (clr) begin
        m_tc = '0; m_dc = '0; m_sc = '0; m_ec = '0;
      end
      e.d  = d;
      e.k  = k;
      e.ev = ev;
    end
    e.tc  = m_tc;
    e.dc  = m_dc;
    e.sc  = m_sc;
    e.ec  = m_ec;
    e.len = m_len;
    exp_q.push_back(e);
  endtask

  task automatic d_sym(input logic [7:0] d, input logic [6:0] ev);
    sym(d, 1'b0, ev, -1, 1'b0, 1'b0);
  endtask

  task automatic k_sym(input logic [7:0] d, input logic [6:0] ev);
    sym(d, 1'b1, ev, -1, 1'b0, 1'b0);
  endtask

  task automatic note(input string s);
    frame_no++;
    $display("frame %0d: %s", frame_no, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) d_sym(8'h00, NOEV);
  endtask

  task automatic skp_os();
    note("SKP ordered set");
    k_sym(COM, NOEV);
    k_sym(SKP, NOEV);
    k_sym(SKP, NOEV);
    k_sym(SKP, E_SKP);
  endtask

  // COM, SKP, [SKP], then D 0x00 where a SKP was due
  task automatic bad_skp(input int pos);
    note($sformatf("short SKP set, break at idx %0d", pos));
    k_sym(COM, NOEV);
    k_sym(SKP, NOEV);
    if (pos == 3) k_sym(SKP, NOEV);
    d_sym(8'h00, E_ERR);
  endtask

  task automatic ts_hdr(input bit fixed);
    k_sym(COM, NOEV);
    if (fixed) begin
      k_sym(PAD, NOEV);
      k_sym(PAD, NOEV);
      d_sym(8'hFF, NOEV);
      d_sym(8'h02, NOEV);
      d_sym(8'h00, NOEV);
    end else begin
      for (int i = 1; i <= 5; i++) begin
        if ($urandom_range(0, 1) == 1) k_sym(PAD, NOEV);
        else                           d_sym(8'($urandom), NOEV);
      end
    end
  endtask

  task automatic ts_os(input logic [7:0] id, input bit fixed);
    note($sformatf("TS ordered set id=%02h", id));
    ts_hdr(fixed);
    for (int i = 6; i <= 15; i++)
      d_sym(id, (i == 15) ? ((id == TS1) ? E_TS1 : E_TS2) : NOEV);
  endtask

  // j good identifiers, then either the other identifier or a K PAD
  task automatic bad_ts(input int j, input bit use_k);
    logic [7:0] id;
    id = ($urandom_range(0, 1) == 1) ? TS1 : TS2;
    note($sformatf("TS broken after %0d ids (k=%0d)", j, use_k));
    ts_hdr(1'b0);
    for (int i = 0; i < j; i++) d_sym(id, NOEV);
    if (use_k) k_sym(PAD, E_ERR);
    else       d_sym((id == TS1) ? TS2 : TS1, E_ERR);
  endtask

  // n = total symbols including STP and terminator; term 1 = EDB
  task automatic tlp(input int n, input bit term, input bit clr_end);
    logic [6:0] ev;
    if (term)                        ev = E_NUL;
    else if (n >= MIN_L && n <= MAX_L) ev = E_TLP;
    else                             ev = E_ERR;
    note($sformatf("TLP len=%0d %s clr=%0d", n, term ? "EDB" : "END", clr_end));
    k_sym(STP, NOEV);
    for (int i = 0; i < n - 2; i++) d_sym(8'($urandom), NOEV);
    sym(term ? EDB : ENDK, 1'b1, ev, n, clr_end, 1'b0);
  endtask

  // TLP cut short by a SKP ordered set, which must still be recognised
  task automatic tlp_com(input int j);
    note($sformatf("TLP cut by COM after %0d data", j));
    k_sym(STP, NOEV);
    for (int i = 0; i < j; i++) d_sym(8'($urandom), NOEV);
    k_sym(COM, E_ERR);
    k_sym(SKP, NOEV);
    k_sym(SKP, NOEV);
    k_sym(SKP, E_SKP);
  endtask

  task automatic dllp(input int nd);
    note($sformatf("DLLP with %0d data", nd));
    k_sym(SDP, NOEV);
    for (int i = 0; i < nd; i++) d_sym(8'($urandom), NOEV);
    k_sym(ENDK, (nd == 6) ? E_DLL : E_ERR);
  endtask

  task automatic stray();
    note("stray data in idle");
    d_sym(8'($urandom_range(1, 255)), E_ERR);
  endtask

  // Monitor: one expected record per clock, compared after the edge settles
  initial begin
    exp_t e;
    forever begin
      @(posedge pclk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({TxDataK, TxData} !== {e.k, e.d}) begin
          errors++;
          $display("FAIL txdata: actual k=%b %02h required k=%b %02h",
                   TxDataK, TxData, e.k, e.d);
        end
        checks++;
        if ({FrameErr, DllpEnd, TlpNull, TlpEnd, Ts2Seen, Ts1Seen, SkpSeen} !== e.ev) begin
          errors++;
          $display("FAIL pulses: actual %b required %b",
                   {FrameErr, DllpEnd, TlpNull, TlpEnd, Ts2Seen, Ts1Seen, SkpSeen}, e.ev);
        end
        checks++;
        if ({TlpCount, DllpCount, SkpCount, ErrCount} !== {e.tc, e.dc, e.sc, e.ec}) begin
          errors++;
          $display("FAIL counters: actual tlp=%0d dllp=%0d skp=%0d err=%0d required tlp=%0d dllp=%0d skp=%0d err=%0d",
                   TlpCount, DllpCount, SkpCount, ErrCount, e.tc, e.dc, e.sc, e.ec);
        end
        checks++;
        if (TlpLen !== e.len) begin
          errors++;
          $display("FAIL tlplen: actual %0d required %0d", TlpLen, e.len);
        end
      end
    end
  end

  initial begin
    // reset, then logical idle
    note("reset");
    for (int i = 0; i < 3; i++) sym(8'h00, 1'b0, NOEV, -1, 1'b0, 1'b1);
    note("idle x20");
    idle(20);

    // SKP: good, then one SKP short
    skp_os();
    idle(1);
    bad_skp(3);
    idle(2);

    // TS1, TS2, then mixed identifiers; the trailing 0x45s are strays in IDLE
    ts_os(TS1, 1'b1);
    ts_os(TS2, 1'b1);
    note("TS mixed 4Ax5 45x5");
    ts_hdr(1'b1);
    for (int i = 0; i < 5; i++) d_sym(TS1, NOEV);
    for (int i = 0; i < 5; i++) d_sym(TS2, E_ERR);
    idle(2);

    // TLP length boundaries and nullification
    tlp(MIN_L, 1'b0, 1'b0);
    tlp(MIN_L - 1, 1'b0, 1'b0);
    tlp(MIN_L, 1'b1, 1'b0);
    idle(1);
    dllp(6);
    dllp(5);
    idle(1);
    tlp(MAX_L, 1'b0, 1'b0);
    tlp(MAX_L + 1, 1'b0, 1'b0);
    idle(2);

    // randomized mix of legal and malformed frames
    for (int f = 0; f < 150; f++) begin
      case ($urandom_range(0, 10))
        0:       skp_os();
        1:       ts_os(($urandom_range(0, 1) == 1) ? TS1 : TS2, 1'b0);
        2:       tlp(int'($urandom_range(MIN_L, MIN_L + 40)), 1'b0, 1'b0);
        3:       tlp(int'($urandom_range(2, MIN_L - 1)), 1'b0, 1'b0);
        4:       tlp(int'($urandom_range(2, 60)), 1'b1, 1'b0);
        5:       dllp(6);
        6:       dllp(int'($urandom_range(0, 5)));
        7:       bad_skp(int'($urandom_range(2, 3)));
        8:       bad_ts(int'($urandom_range(1, 9)), 1'($urandom_range(0, 1)));
        9:       tlp_com(int'($urandom_range(1, 10)));
        default: stray();
      endcase
      idle(int'($urandom_range(0, 3)));
    end

    // reset on the 10th TLP symbol discards the frame; a DLLP follows
    note("TLP interrupted by reset, then DLLP");
    k_sym(STP, NOEV);
    for (int i = 0; i < 8; i++) d_sym(8'($urandom), NOEV);
    sym(8'($urandom), 1'b0, NOEV, -1, 1'b0, 1'b1);
    dllp(6);
    idle(2);

    // counter saturation region: clear racing an increment, then a wrap
    note("fill TlpCount to max");
    while (m_tc != '1) tlp(MIN_L, 1'b0, 1'b0);
    tlp(MIN_L, 1'b0, 1'b1);
    note("refill TlpCount to max");
    while (m_tc != '1) tlp(MIN_L, 1'b0, 1'b0);
    tlp(MIN_L, 1'b0, 1'b0);
    idle(3);

    repeat (4) @(negedge pclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
